// File: rtl/strobe_cap_pkg.sv
// Shared types and helpers for the strobe capture FIFO.
//   DW_DEFAULT / DEPTH_DEFAULT : default data width and FIFO depth
//   entry_t                    : stored word, secure tag plus data
//   lvl_w()                    : occupancy counter width for a given depth
package strobe_cap_pkg;

    localparam int unsigned DW_DEFAULT    = 32;
    localparam int unsigned DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic                  secure;
        logic [DW_DEFAULT-1:0] data;
    } entry_t;

    // One extra bit so that level can represent DEPTH itself.
    function automatic int unsigned lvl_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cap_fifo_core.sv
// Generic first-word-fall-through FIFO.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : synchronous flush, wins over push/pop
//   push_i        : write wdata_i; ignored when full unless a pop happens in the same cycle
//   pop_i         : consume the head word; ignored when empty
//   rdata_o       : head word (raw storage, caller qualifies with empty_o)
//   full_o        : level == DEPTH
//   empty_o       : level == 0
//   level_o       : current occupancy
module cap_fifo_core
    import strobe_cap_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter type         T     = entry_t
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clr_i,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  T                          wdata_i,
    output T                          rdata_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [lvl_w(DEPTH)-1:0]   level_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = lvl_w(DEPTH);

    T                mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0] level_q, level_d;

    logic push_ok;
    logic pop_ok;

    assign full_o  = (level_q == LvlW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // At full a simultaneous pop frees the slot the push writes into.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + LvlW'(1);
                2'b01:   level_d = level_q - LvlW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is deliberately left unreset; readers gate it with empty_o.
    always_ff @(posedge clk_i) begin
        if (push_ok && !clr_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/strobe_capture_fifo.sv
// Captures single-cycle source strobes into a FWFT FIFO and forwards them over valid/ready.
//   clk, rst1   : clock, asynchronous active-low reset
//   status      : source not ready; strobes seen while high are protocol errors
//   strobe      : source data-valid pulse; only the first cycle of a high run is captured
//   secure_out  : secure tag sampled with strobe
//   data        : source data word
//   clr         : synchronous flush of FIFO and sticky flags
//   out_ready   : sink accepts the head word
//   out_valid   : head word available
//   out_data    : head word, zero while empty
//   out_secure  : secure tag of the head word, zero while empty
//   level       : current occupancy
//   overflow    : sticky, a word was dropped at full
//   proto_err   : sticky, strobe while busy or strobe held longer than one cycle
module strobe_capture_fifo
    import strobe_cap_pkg::*;
#(
    parameter int unsigned DEPTH       = DEPTH_DEFAULT,
    parameter int unsigned DW          = DW_DEFAULT,
    parameter int unsigned SECURE_MASK = 1
) (
    input  logic                    clk,
    input  logic                    rst1,
    input  logic                    status,
    input  logic                    strobe,
    input  logic                    secure_out,
    input  logic [DW-1:0]           data,
    input  logic                    clr,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [DW-1:0]           out_data,
    output logic                    out_secure,
    output logic [lvl_w(DEPTH)-1:0] level,
    output logic                    overflow,
    output logic                    proto_err
);

    typedef struct packed {
        logic          secure;
        logic [DW-1:0] data;
    } cap_entry_t;

    logic       prev_strobe_q;
    logic       overflow_q, overflow_d;
    logic       proto_err_q, proto_err_d;

    logic       push;
    logic       pop;
    logic       strobe_err;
    logic       fifo_full;
    logic       fifo_empty;
    cap_entry_t wr_entry;
    cap_entry_t head;

    assign push       = strobe & ~prev_strobe_q & ~status;
    assign strobe_err = strobe & (status | prev_strobe_q);
    assign pop        = out_valid & out_ready;

    assign wr_entry.secure = secure_out;
    assign wr_entry.data   = data;

    cap_fifo_core #(
        .DEPTH (DEPTH),
        .T     (cap_entry_t)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst1),
        .clr_i   (clr),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    always_comb begin
        overflow_d  = overflow_q;
        proto_err_d = proto_err_q;
        if (clr) begin
            overflow_d  = 1'b0;
            proto_err_d = 1'b0;
        end else begin
            if (push && fifo_full && !pop) begin
                overflow_d = 1'b1;
            end
            if (strobe_err) begin
                proto_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst1) begin
        if (!rst1) begin
            prev_strobe_q <= 1'b0;
            overflow_q    <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            prev_strobe_q <= strobe;
            overflow_q    <= overflow_d;
            proto_err_q   <= proto_err_d;
        end
    end

    // Empty storage may hold stale, possibly secure, words: zeroing the data whenever nothing is
    // valid covers the secure-mask case too, so SECURE_MASK has no further effect here.
    logic unused_secure_mask;
    assign unused_secure_mask = SECURE_MASK[0];

    assign out_valid  = ~fifo_empty;
    assign out_data   = out_valid ? head.data : '0;
    assign out_secure = out_valid & head.secure;
    assign overflow   = overflow_q;
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_strobe_capture_fifo.sv
module tb_strobe_capture_fifo;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst1 = 1'b0;
    logic          status = 1'b1;
    logic          strobe = 1'b0;
    logic          secure_out = 1'b0;
    logic [DW-1:0] data = '0;
    logic          clr = 1'b0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_secure;
    logic [LW-1:0] level;
    logic          overflow;
    logic          proto_err;

    strobe_capture_fifo #(
        .DEPTH       (DEPTH),
        .DW          (DW),
        .SECURE_MASK (1)
    ) dut (
        .clk        (clk),
        .rst1       (rst1),
        .status     (status),
        .strobe     (strobe),
        .secure_out (secure_out),
        .data       (data),
        .clr        (clr),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_secure (out_secure),
        .level      (level),
        .overflow   (overflow),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          sec;
        logic [DW-1:0] d;
    } exp_t;

    exp_t sb[$];
    logic m_prev = 1'b0;
    logic m_ovf  = 1'b0;
    logic m_perr = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every output against the model; called at the falling edge.
    task automatic check_outputs();
        exp_t head;
        head = '0;
        if (sb.size() != 0) head = sb[0];
        check_eq("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        check_eq("level", 64'(level), 64'(sb.size()));
        check_eq("out_data", 64'(out_data), 64'(head.d));
        check_eq("out_secure", 64'(out_secure), 64'(head.sec));
        check_eq("overflow", 64'(overflow), 64'(m_ovf));
        check_eq("proto_err", 64'(proto_err), 64'(m_perr));
    endtask

    // One clock cycle: check, drive inputs, advance the model, move to the next falling edge.
    task automatic step(input logic s, input logic st, input logic [DW-1:0] d, input logic sec,
                        input logic rdy, input logic c);
        logic push_m, pop_m, err_m, full_m;
        exp_t e;
        check_outputs();
        push_m = s & ~m_prev & ~st;
        pop_m  = (sb.size() != 0) & rdy;
        err_m  = s & (st | m_prev);
        full_m = (sb.size() == DEPTH);
        strobe = s; status = st; data = d; secure_out = sec; out_ready = rdy; clr = c;
        if (c) begin
            sb.delete();
            m_ovf  = 1'b0;
            m_perr = 1'b0;
        end else begin
            if (pop_m) begin
                e = sb.pop_front();
                check_eq("pop_data", 64'(out_data), 64'(e.d));
                check_eq("pop_secure", 64'(out_secure), 64'(e.sec));
            end
            if (push_m) begin
                if (!full_m || pop_m) sb.push_back('{sec: sec, d: d});
                else m_ovf = 1'b1;
            end
            if (err_m) m_perr = 1'b1;
        end
        m_prev = s;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, rdy, 1'b0);
    endtask

    task automatic pulse(input logic [DW-1:0] d, input logic sec);
        step(1'b1, 1'b0, d, sec, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check_outputs();
        @(negedge clk);
        rst1 = 1'b1;

        // Reset release: status busy 9 cycles, then strobe 5 cycles later
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        step(1'b1, 1'b0, 32'hFF, 1'b1, 1'b0, 1'b0);
        check_eq("rel_valid", 64'(out_valid), 64'd1);
        check_eq("rel_data", 64'(out_data), 64'hFF);
        check_eq("rel_secure", 64'(out_secure), 64'd1);
        check_eq("rel_level", 64'(level), 64'd1);
        idle(2, 1'b1);

        // Strobe while status busy
        step(1'b1, 1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
        check_eq("busy_level", 64'(level), 64'd0);
        check_eq("busy_perr", 64'(proto_err), 64'd1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Strobe held for three cycles
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h12, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        check_eq("held_level", 64'(level), 64'd1);
        check_eq("held_data", 64'(out_data), 64'h12);
        check_eq("held_perr", 64'(proto_err), 64'd1);
        idle(2, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Fill past full
        for (int i = 1; i <= 5; i++) pulse(DW'(i), 1'b0);
        check_eq("fill_level", 64'(level), 64'd4);
        check_eq("fill_ovf", 64'(overflow), 64'd1);
        idle(5, 1'b1);
        check_eq("drain_empty", 64'(out_valid), 64'd0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Simultaneous push and pop at full
        for (int i = 1; i <= 4; i++) pulse(DW'(i), 1'b1);
        step(1'b1, 1'b0, 32'h9, 1'b0, 1'b1, 1'b0);
        check_eq("pp_level", 64'(level), 64'd4);
        check_eq("pp_ovf", 64'(overflow), 64'd0);
        check_eq("pp_head", 64'(out_data), 64'd2);
        idle(5, 1'b1);

        // Flush with a strobe in the same cycle, flags set beforehand
        step(1'b1, 1'b0, 32'h31, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h31, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        pulse(32'h32, 1'b1);
        pulse(32'h33, 1'b0);
        check_eq("pre_clr_level", 64'(level), 64'd3);
        step(1'b1, 1'b0, 32'hAA, 1'b1, 1'b0, 1'b1);
        check_eq("clr_level", 64'(level), 64'd0);
        check_eq("clr_valid", 64'(out_valid), 64'd0);
        check_eq("clr_data", 64'(out_data), 64'd0);
        check_eq("clr_perr", 64'(proto_err), 64'd0);
        idle(1, 1'b0);

        // Reset asserted mid-drain
        pulse(32'hA1, 1'b1);
        pulse(32'hA2, 1'b0);
        pulse(32'hA3, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        #2 rst1 = 1'b0;
        #1;
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_level", 64'(level), 64'd0);
        check_eq("rst_data", 64'(out_data), 64'd0);
        check_eq("rst_secure", 64'(out_secure), 64'd0);
        sb.delete();
        m_ovf = 1'b0; m_perr = 1'b0; m_prev = 1'b0;
        strobe = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst1 = 1'b1;
        pulse(32'h77, 1'b0);
        idle(2, 1'b1);

        // Random traffic against the model
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 2) == 0, $urandom_range(0, 6) == 0, DW'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                 $urandom_range(0, 40) == 0);
        end
        idle(6, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/strobe_capture_fifo.md
Name: strobe_capture_fifo

Overview:
- Downstream consumer of the secure data source's strobe/data/status/secure_out outputs.
- Captures each single-cycle strobe word into a small first-word-fall-through FIFO and tags it with its secure bit.
- Presents the words to the bridge's transmit side over a valid/ready handshake.
- Enforces the source protocol: one-cycle strobe, and no strobe while status is high. Violations are flagged, never forwarded.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16
- DW, 32, data width
- SECURE_MASK, 1, 1 = zero out_data of secure words while out_valid is low

Ports:
- clk  in  1  clock; all state on posedge
- rst1  in  1  asynchronous active-low reset
- status  in  1  source busy/reset indicator; high = source not ready
- strobe  in  1  source data-valid pulse, nominally one cycle
- secure_out  in  1  source secure flag, sampled with strobe
- data  in  DW  source data word
- clr  in  1  synchronous flush: empty the FIFO, clear all sticky flags
- out_ready  in  1  sink accepts a word
- out_valid  out  1  head word available
- out_data  out  DW  head word
- out_secure  out  1  secure tag of the head word
- level  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: a word was dropped because the FIFO was full
- proto_err  out  1  sticky: a strobe protocol violation was detected

Behaviour:
- Reset (rst1 low, asynchronous): all outputs are 0. Pointers, level, sticky flags and prev_strobe are cleared.
- The storage array is not reset. out_data must still read 0 while empty.
- Capture qualifier: push = strobe & !prev_strobe & !status. prev_strobe is strobe registered once.
- Strobe high while status high:
  - No push.
  - proto_err set at the next edge.
- Strobe high on two consecutive cycles:
  - The first cycle pushes (if otherwise qualified).
  - Each further high cycle is ignored and sets proto_err.
- Pop = out_valid & out_ready.
- FWFT latency: a word pushed at edge N is visible on out_valid/out_data at N+1 when the FIFO was empty (registered, one cycle).
- Full (level == DEPTH):
  - push & !pop → word dropped, overflow set, level unchanged.
  - push & pop in the same cycle → both happen, level stays DEPTH, no overflow.
- Empty: pop is impossible (out_valid = 0), and out_data = 0.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. level is tracked separately.
- Secure masking: when SECURE_MASK = 1 and the head entry is secure, out_data reads 0 whenever out_valid is low. This does not occur while entries exist, so the effective rule is that out_data is 0 while empty.
- A secure word is delivered unmasked when valid.
- clr (synchronous):
  - Next edge: level = 0, out_valid = 0, overflow = 0, proto_err = 0.
  - clr has priority over push/pop in that cycle; the pushed word is discarded.
- rst1 asserted mid-stream: all content is lost immediately. out_valid drops asynchronously.
- No internal state machine beyond the FIFO. The control logic is: capture qualifier → write; handshake → read; sticky flag set/clear.

Decomposition:
- Package strobe_cap_pkg holds:
  - DW_DEFAULT, DEPTH_DEFAULT
  - entry_t: packed struct of secure bit + data[DW-1:0]
  - LVL_W function (clog2 + 1)
- One sub-module: cap_fifo_core, a generic FWFT FIFO with push/pop/full/empty/level/clr over entry_t.
- The top holds the strobe qualifier, the sticky flags and the masking mux.

Test Plan:
- Reset release:
  - Stimulus: rst1 rises, status falls 9 cycles later, strobe pulses 5 cycles after that with data = 'hFF, secure_out = 1.
  - Response: out_valid = 1 one cycle after strobe, out_data = 'hFF, out_secure = 1, level = 1.
- Protocol errors:
  - Strobe while status = 1 → no push, level = 0, proto_err = 1 next cycle.
  - Strobe held 3 cycles with data 'h12 → exactly one entry 'h12, proto_err = 1.
- Fill to full:
  - Stimulus: DEPTH = 4, out_ready = 0, 5 qualified strobes with data 1..5.
  - Response: level = 4, overflow = 1. Draining yields 1, 2, 3, 4; 5 is lost.
- Simultaneous push/pop at full:
  - Stimulus: full with 1..4, out_ready = 1 for one cycle with a strobe of data 9.
  - Response: pops 1, level stays 4, overflow stays 0, order 2, 3, 4, 9.
- Flush and reset:
  - clr asserted together with a strobe while level = 3 → next cycle level = 0, out_valid = 0, out_data = 0, flags = 0.
  - rst1 pulsed low mid-drain → outputs 0 asynchronously.
